match_scoreboard: RTL and testbench
===================================

// Module: match_scoreboard
// PURPOSE
//  Downstream consumer of the target-score selector. Latches the selected target (0..21),
//  counts per-player points from the ball/collision logic and paces serves.
//  Declares the first player to reach the target as the winner.
//  Feeds the 7-seg/VGA score display (BCD) and the ball launcher (serve pulse).
// PARAMETERS
//  SCORE_W      6            width of scores and target
//  SERVE_DELAY  100_000_000  cycles paused after start/point before serve (1 s @100 MHz); must be >=1
//  CNT_W        $clog2(SERVE_DELAY+1)  serve-timer width (derived, localparam)
// PORTS
//  clk          in   1        system clock, all logic on posedge
//  rst          in   1        asynchronous, active-high reset
//  target_score in   SCORE_W  selected max score from score-select stage (0..21)
//  start        in   1        1-cycle pulse (debounced button) to begin a match
//  point_p1     in   1        1-cycle pulse: player 1 scored
//  point_p2     in   1        1-cycle pulse: player 2 scored
//  score_p1     out  SCORE_W  player 1 score (registered)
//  score_p2     out  SCORE_W  player 2 score (registered)
//  bcd_p1       out  8        {tens,ones} BCD of score_p1 (combinational from register)
//  bcd_p2       out  8        {tens,ones} BCD of score_p2
//  serve        out  1        1-cycle pulse: launch ball
//  playing      out  1        high while state==PLAY
//  game_over    out  1        high while state==OVER
//  winner       out  2        00 none, 01 player1, 10 player2 (11 never)
// BEHAVIOUR
//  Reset: state IDLE; scores 0, target_q 0, timer 0, serve 0, winner 00, game_over 0, playing 0.
//  FSM states: IDLE, SERVE, PLAY, OVER.
//  IDLE --start--> SERVE: clear scores, winner=00, latch target_q=max(target_score,1), timer=0.
//  OVER --start--> SERVE: same actions as from IDLE.
//  start in SERVE/PLAY: ignored (no restart mid-match).
//  SERVE: timer counts up each cycle; when timer==SERVE_DELAY-1 -> PLAY, serve=1 for that one
//   cycle (registered, visible the cycle PLAY begins), timer cleared. Point pulses ignored.
//  PLAY: exactly one of point_p1/point_p2 high -> that score +1 on the same edge.
//   If new score == target_q -> OVER, winner set, game_over=1 on same edge; else -> SERVE.
//  PLAY, point_p1 && point_p2 same cycle: collision artefact; neither counted, stay in PLAY.
//  OVER: scores and winner held until start; point pulses ignored.
//  Target latched only at start; target_score changes mid-match have no effect.
//  target_score 0 is treated as 1; values >21 are used as-is (saturate at 2^SCORE_W-1 never
//   reached since match ends at target).
//  Scores never exceed target_q, so no wrap-around.
//  Async rst mid-match: immediate return to reset values, serve deasserted.
//  Latency: point pulse at edge N -> score/game_over/winner updated at edge N; BCD same cycle.
// STRUCTURE
//  Shared package pong_pkg: state encoding localparams (IDLE=0,SERVE=1,PLAY=2,OVER=3),
//   winner codes (WIN_NONE/WIN_P1/WIN_P2), MAX_TARGET=21.
//  Sub-module bin2bcd_6: combinational 6-bit binary -> 2-digit BCD, instanced twice.
//  Top: FSM + serve timer + two score registers, single always block per register group.
// TESTING (SERVE_DELAY=4)
//  rst pulse mid-SERVE -> all outputs return to reset values immediately, no serve pulse.
//  target=3, start -> serve pulse exactly 4 cycles after start edge, playing=1 thereafter.
//  target=3: p1,p2,p1,p1 points (each after serve) -> scores 3/1, winner=01, game_over=1,
//   bcd_p1=8'h03; further point_p2 pulses leave score_p2=1.
//  point_p1 and point_p2 in same PLAY cycle -> scores unchanged, playing stays 1, no serve.
//  target_score=0, start -> one point from p2 ends match: score_p2=1, winner=10.
//  target=21, p1 wins 21-0 -> bcd_p1=8'h21; change target_score mid-match -> no effect;
//   start from OVER -> scores 0, winner 00, new serve after 4 cycles.

Source files
------------

// File: rtl/pong_pkg.sv
// ============================================================================
// Module   : pong_pkg
// Brief    : Shared FSM state encoding, winner codes and score limits.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pong_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        PLAY  = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    localparam int MAX_TARGET = 21;

endpackage

`default_nettype wire

// File: rtl/bin2bcd_6.sv
// ============================================================================
// Module   : bin2bcd_6
// Brief    : Combinational 6-bit binary to two-digit BCD {tens,ones}.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bin2bcd_6 (
    input  logic [5:0] i_bin,
    output logic [7:0] o_bcd
);

    logic [3:0] w_tens;
    logic [3:0] w_ones;

    // Compare ladder avoids a generic divider for a 0..63 range.
    always_comb begin
        w_tens = 4'd0;
        w_ones = i_bin[3:0];
        if (i_bin >= 6'd60) begin
            w_tens = 4'd6;
            w_ones = 4'(i_bin - 6'd60);
        end else if (i_bin >= 6'd50) begin
            w_tens = 4'd5;
            w_ones = 4'(i_bin - 6'd50);
        end else if (i_bin >= 6'd40) begin
            w_tens = 4'd4;
            w_ones = 4'(i_bin - 6'd40);
        end else if (i_bin >= 6'd30) begin
            w_tens = 4'd3;
            w_ones = 4'(i_bin - 6'd30);
        end else if (i_bin >= 6'd20) begin
            w_tens = 4'd2;
            w_ones = 4'(i_bin - 6'd20);
        end else if (i_bin >= 6'd10) begin
            w_tens = 4'd1;
            w_ones = 4'(i_bin - 6'd10);
        end
    end

    assign o_bcd = {w_tens, w_ones};

endmodule

`default_nettype wire

// File: rtl/match_scoreboard.sv
// ============================================================================
// Module   : match_scoreboard
// Brief    : Match FSM with serve pacing, per-player scoring and BCD outputs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module match_scoreboard
    import pong_pkg::*;
#(
    parameter int SCORE_W     = 6,
    parameter int SERVE_DELAY = 100_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SCORE_W-1:0] target_score,
    input  logic               start,
    input  logic               point_p1,
    input  logic               point_p2,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic [7:0]         bcd_p1,
    output logic [7:0]         bcd_p2,
    output logic               serve,
    output logic               playing,
    output logic               game_over,
    output logic [1:0]         winner
);

    localparam int CNT_W = $clog2(SERVE_DELAY + 1);
    localparam logic [CNT_W-1:0] c_TIMER_LAST = CNT_W'(SERVE_DELAY - 1);

    state_t             r_state,    w_state_nxt;
    logic [CNT_W-1:0]   r_timer,    w_timer_nxt;
    logic [SCORE_W-1:0] r_score_p1, w_score_p1_nxt;
    logic [SCORE_W-1:0] r_score_p2, w_score_p2_nxt;
    logic [SCORE_W-1:0] r_target,   w_target_nxt;
    logic [1:0]         r_winner,   w_winner_nxt;
    logic               r_serve,    w_serve_nxt;

    logic [SCORE_W-1:0] w_inc_p1;
    logic [SCORE_W-1:0] w_inc_p2;

    assign w_inc_p1 = r_score_p1 + 1'b1;
    assign w_inc_p2 = r_score_p2 + 1'b1;

    always_comb begin
        w_state_nxt    = r_state;
        w_timer_nxt    = r_timer;
        w_score_p1_nxt = r_score_p1;
        w_score_p2_nxt = r_score_p2;
        w_target_nxt   = r_target;
        w_winner_nxt   = r_winner;
        w_serve_nxt    = 1'b0;

        case (r_state)
            IDLE, OVER: begin
                if (start) begin
                    w_state_nxt    = SERVE;
                    w_score_p1_nxt = '0;
                    w_score_p2_nxt = '0;
                    w_winner_nxt   = WIN_NONE;
                    w_timer_nxt    = '0;
                    // A zero target would end the match before any play.
                    w_target_nxt   = (target_score == '0) ? SCORE_W'(1) : target_score;
                end
            end
            SERVE: begin
                if (r_timer == c_TIMER_LAST) begin
                    w_state_nxt = PLAY;
                    w_serve_nxt = 1'b1;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            PLAY: begin
                // Simultaneous pulses are a collision artefact and are dropped.
                if (point_p1 && !point_p2) begin
                    w_score_p1_nxt = w_inc_p1;
                    if (w_inc_p1 == r_target) begin
                        w_state_nxt  = OVER;
                        w_winner_nxt = WIN_P1;
                    end else begin
                        w_state_nxt = SERVE;
                    end
                end else if (point_p2 && !point_p1) begin
                    w_score_p2_nxt = w_inc_p2;
                    if (w_inc_p2 == r_target) begin
                        w_state_nxt  = OVER;
                        w_winner_nxt = WIN_P2;
                    end else begin
                        w_state_nxt = SERVE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_timer    <= '0;
            r_score_p1 <= '0;
            r_score_p2 <= '0;
            r_target   <= '0;
            r_winner   <= WIN_NONE;
            r_serve    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_score_p1 <= w_score_p1_nxt;
            r_score_p2 <= w_score_p2_nxt;
            r_target   <= w_target_nxt;
            r_winner   <= w_winner_nxt;
            r_serve    <= w_serve_nxt;
        end
    end

    bin2bcd_6 u_bcd_p1 (
        .i_bin (r_score_p1),
        .o_bcd (bcd_p1)
    );

    bin2bcd_6 u_bcd_p2 (
        .i_bin (r_score_p2),
        .o_bcd (bcd_p2)
    );

    assign score_p1  = r_score_p1;
    assign score_p2  = r_score_p2;
    assign serve     = r_serve;
    assign winner    = r_winner;
    assign playing   = (r_state == PLAY);
    assign game_over = (r_state == OVER);

endmodule

`default_nettype wire

// File: tb/tb_match_scoreboard.sv
// ============================================================================
// Module   : tb_match_scoreboard
// Brief    : Directed self-checking bench for match_scoreboard (SERVE_DELAY=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_match_scoreboard;

    localparam int SCORE_W     = 6;
    localparam int SERVE_DELAY = 4;

    logic               clk;
    logic               rst;
    logic [SCORE_W-1:0] target_score;
    logic               start;
    logic               point_p1;
    logic               point_p2;
    logic [SCORE_W-1:0] score_p1;
    logic [SCORE_W-1:0] score_p2;
    logic [7:0]         bcd_p1;
    logic [7:0]         bcd_p2;
    logic               serve;
    logic               playing;
    logic               game_over;
    logic [1:0]         winner;

    int n_checks;
    int n_errors;

    match_scoreboard #(
        .SCORE_W     (SCORE_W),
        .SERVE_DELAY (SERVE_DELAY)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .target_score (target_score),
        .start        (start),
        .point_p1     (point_p1),
        .point_p2     (point_p2),
        .score_p1     (score_p1),
        .score_p2     (score_p2),
        .bcd_p1       (bcd_p1),
        .bcd_p2       (bcd_p2),
        .serve        (serve),
        .playing      (playing),
        .game_over    (game_over),
        .winner       (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_point(input logic p1, input logic p2);
        @(negedge clk);
        point_p1 = p1;
        point_p2 = p2;
        @(negedge clk);
        point_p1 = 1'b0;
        point_p2 = 1'b0;
    endtask

    // Returns the number of falling edges until serve is seen, or -1.
    task automatic wait_serve(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (serve === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({score_p1, score_p2, serve, playing, game_over, winner} !== 17'd0) begin
            n_errors++;
            $display("FAIL reset_state: got p1=%0d p2=%0d serve=%b play=%b over=%b win=%b, want all 0",
                     score_p1, score_p2, serve, playing, game_over, winner);
        end
        rst = 1'b0;
        target_score = 6'd3;
        pulse_start();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({score_p1, score_p2, serve, playing, game_over, winner} !== 17'd0) begin
            n_errors++;
            $display("FAIL reset_async: got serve=%b play=%b over=%b win=%b, want all 0",
                     serve, playing, game_over, winner);
        end
        @(negedge clk);
        rst = 1'b0;
        wait_serve(n);
        n_checks++;
        if (n != -1) begin
            n_errors++;
            $display("FAIL reset_no_serve: serve seen after %0d cycles, want none", n);
        end
    endtask

    task automatic test_serve_timing();
        int n;
        target_score = 6'd3;
        pulse_start();
        n_checks++;
        if (score_p1 !== 6'd0 || score_p2 !== 6'd0 || winner !== 2'b00 || playing !== 1'b0) begin
            n_errors++;
            $display("FAIL start_clear: got p1=%0d p2=%0d win=%b play=%b, want 0 0 00 0",
                     score_p1, score_p2, winner, playing);
        end
        wait_serve(n);
        n_checks++;
        if (n != 4) begin
            n_errors++;
            $display("FAIL serve_latency: got %0d cycles, want 4", n);
        end
        n_checks++;
        if (playing !== 1'b1) begin
            n_errors++;
            $display("FAIL playing_after_serve: got %b, want 1", playing);
        end
    endtask

    task automatic test_collision();
        int n;
        pulse_point(1'b1, 1'b1);
        n_checks++;
        if (score_p1 !== 6'd0 || score_p2 !== 6'd0 || playing !== 1'b1) begin
            n_errors++;
            $display("FAIL collision: got p1=%0d p2=%0d play=%b, want 0 0 1",
                     score_p1, score_p2, playing);
        end
        wait_serve(n);
        n_checks++;
        if (n != -1) begin
            n_errors++;
            $display("FAIL collision_no_serve: serve seen after %0d cycles, want none", n);
        end
    endtask

    task automatic test_scoring();
        logic [1:0] seq [4];
        logic [5:0] exp_p1 [4];
        logic [5:0] exp_p2 [4];
        int n;
        seq    = '{2'b01, 2'b10, 2'b01, 2'b01};
        exp_p1 = '{6'd1, 6'd1, 6'd2, 6'd3};
        exp_p2 = '{6'd0, 6'd1, 6'd1, 6'd1};
        for (int i = 0; i < 4; i++) begin
            pulse_point(seq[i][0], seq[i][1]);
            n_checks++;
            if (score_p1 !== exp_p1[i] || score_p2 !== exp_p2[i]) begin
                n_errors++;
                $display("FAIL score_step%0d: got %0d/%0d, want %0d/%0d",
                         i, score_p1, score_p2, exp_p1[i], exp_p2[i]);
            end
            if (i < 3) begin
                wait_serve(n);
                n_checks++;
                if (n != 4) begin
                    n_errors++;
                    $display("FAIL reserve_step%0d: got %0d cycles, want 4", i, n);
                end
            end
        end
        n_checks++;
        if (winner !== 2'b01 || game_over !== 1'b1 || playing !== 1'b0 || bcd_p1 !== 8'h03 || bcd_p2 !== 8'h01) begin
            n_errors++;
            $display("FAIL p1_wins: got win=%b over=%b play=%b bcd=%h/%h, want 01 1 0 03/01",
                     winner, game_over, playing, bcd_p1, bcd_p2);
        end
        pulse_point(1'b0, 1'b1);
        pulse_point(1'b0, 1'b1);
        n_checks++;
        if (score_p2 !== 6'd1 || winner !== 2'b01 || game_over !== 1'b1) begin
            n_errors++;
            $display("FAIL over_hold: got p2=%0d win=%b over=%b, want 1 01 1",
                     score_p2, winner, game_over);
        end
    endtask

    task automatic test_target_zero();
        int n;
        target_score = 6'd0;
        pulse_start();
        wait_serve(n);
        pulse_point(1'b0, 1'b1);
        n_checks++;
        if (score_p2 !== 6'd1 || score_p1 !== 6'd0 || winner !== 2'b10 || game_over !== 1'b1) begin
            n_errors++;
            $display("FAIL target_zero: got %0d/%0d win=%b over=%b, want 0/1 10 1",
                     score_p1, score_p2, winner, game_over);
        end
    endtask

    task automatic test_target_21();
        int n;
        target_score = 6'd21;
        pulse_start();
        for (int i = 1; i <= 21; i++) begin
            wait_serve(n);
            if (n == -1) begin
                n_checks++;
                n_errors++;
                $display("FAIL t21_serve_timeout: point %0d, got no serve, want serve", i);
                break;
            end
            if (i == 3) target_score = 6'd5;
            pulse_point(1'b1, 1'b0);
            if (i == 10) begin
                n_checks++;
                if (game_over !== 1'b0 || bcd_p1 !== 8'h10) begin
                    n_errors++;
                    $display("FAIL t21_midmatch: got over=%b bcd=%h, want 0 10", game_over, bcd_p1);
                end
            end
        end
        n_checks++;
        if (score_p1 !== 6'd21 || bcd_p1 !== 8'h21 || winner !== 2'b01 || game_over !== 1'b1) begin
            n_errors++;
            $display("FAIL t21_win: got p1=%0d bcd=%h win=%b over=%b, want 21 21 01 1",
                     score_p1, bcd_p1, winner, game_over);
        end
    endtask

    task automatic test_restart();
        int n;
        pulse_start();
        n_checks++;
        if (score_p1 !== 6'd0 || score_p2 !== 6'd0 || winner !== 2'b00 || game_over !== 1'b0 || bcd_p1 !== 8'h00) begin
            n_errors++;
            $display("FAIL restart_clear: got %0d/%0d win=%b over=%b bcd=%h, want 0/0 00 0 00",
                     score_p1, score_p2, winner, game_over, bcd_p1);
        end
        wait_serve(n);
        n_checks++;
        if (n != 4) begin
            n_errors++;
            $display("FAIL restart_serve: got %0d cycles, want 4", n);
        end
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b1;
        start        = 1'b0;
        point_p1     = 1'b0;
        point_p2     = 1'b0;
        target_score = 6'd0;
        test_reset();
        test_serve_timing();
        test_collision();
        test_scoring();
        test_target_zero();
        test_target_21();
        test_restart();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
